demux_stream: RTL and testbench
===============================

// Module: demux_stream
//
// PURPOSE
//   Parametrised, registered 1-to-N stream demultiplexer. It is the clocked, handshaked successor to the
//   combinational 1-to-8 demux. One input stream (valid/ready) is steered by a select field to one of N
//   output channels, or broadcast to all of them. Each channel has a one-entry output register, so a
//   stalled channel does not lose data. It sits between a single producer and N independent consumers.
//
// PARAMETERS
//   N     8   number of output channels (>=2; need not be a power of 2)
//   DW    8   data width in bits
//   CW    8   width of the saturating drop counter
//   SW    -   localparam = (N>1) ? $clog2(N) : 1; width of in_sel
//
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input word present
//   in_ready   out  1      block accepts input word this cycle
//   in_data    in   DW     input word
//   in_sel     in   SW     destination channel index
//   in_bcast   in   1      1 = deliver word to all N channels (in_sel ignored)
//   out_valid  out  N      per-channel output word present
//   out_ready  in   N      per-channel consumer accepts word
//   out_data   out  N*DW   channel k data at [k*DW +: DW]
//   err        out  1      one-cycle pulse: a word with out-of-range in_sel was dropped
//   drop_cnt   out  CW     saturating count of dropped words
//
// BEHAVIOUR
//   - Reset (async assert, sync-released use): out_valid=0, out_data=0, err=0, drop_cnt=0.
//     Reset mid-operation discards all held words; no partial state survives.
//   - can_acc[k] = !out_valid[k] | out_ready[k]. This allows pass-through at full rate per channel.
//   - in_ready is combinational from in_sel, in_bcast, out_valid and out_ready. It never depends on in_valid.
//       bcast=1          : in_ready = &can_acc (all-or-nothing; no partial broadcast)
//       bcast=0, sel<N   : in_ready = can_acc[sel]
//       bcast=0, sel>=N  : in_ready = 1 (word is sunk)
//   - A transfer occurs when in_valid & in_ready.
//     Unicast: out_data[sel]<=in_data, out_valid[sel]<=1.
//     Broadcast: every channel is loaded and every out_valid is set.
//   - Latency is 1 cycle from input transfer to out_valid. Throughput is 1 word/cycle when consumers are ready.
//   - Channel k while out_valid[k] & !out_ready[k]: out_data[k] and out_valid[k] hold stable.
//   - Channel k drain (out_valid & out_ready) with no reload in the same cycle: out_valid[k]<=0.
//     out_data[k] keeps its last value.
//   - Simultaneous drain and reload of the same channel: out_valid stays 1 and out_data takes the new word.
//   - Out-of-range drop: on a transfer with bcast=0 and sel>=N, no channel changes.
//     The next cycle err=1 (one cycle only), and drop_cnt increments, saturating at 2^CW-1.
//     Back-to-back drops give err high on consecutive cycles.
//   - Channels are independent: a stall on channel j never blocks unicast traffic to channel k!=j.
//   - in_valid=0: no state change apart from drains.
//
// TESTING
//   1 Reset, then send in_sel=3, data=0xA5 with all out_ready=1:
//     the next cycle out_valid=8'b0000_1000, out_data[3]=0xA5; the cycle after, out_valid=0.
//   2 Hold out_ready[2]=0 and send two words to ch2:
//     first accepted; in_ready=0 for the second until out_ready[2]=1, then 0x11 then 0x22 emerge in order.
//   3 Stall ch5 and stream to ch0 every cycle:
//     in_ready=1 throughout and ch0 receives 1 word/cycle.
//   4 bcast=1, data=0x3C, with out_ready[6]=0 and ch6 full:
//     in_ready=0. Release ch6 -> accepted, and all 8 channels show 0x3C next cycle.
//   5 N=6, in_sel=7:
//     in_ready=1, err pulses 1 cycle, drop_cnt 0->1, no out_valid change.
//     With CW=2, 5 drops -> drop_cnt=3.
//   6 Assert rst_n=0 while ch1 and ch4 hold words:
//     out_valid=0, drop_cnt=0 and err=0 immediately (no clock edge needed).

Source files
------------

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with broadcast and out-of-range drop accounting.
// Each channel owns a one-entry output register; a stalled channel never blocks the others.
module demux_stream #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8,
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [SW-1:0]   in_sel,
    input  logic            in_bcast,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [N*DW-1:0] out_data,
    output logic            err,
    output logic [CW-1:0]   drop_cnt
);

    logic [N-1:0]          valid_q, valid_d;
    logic [N-1:0][DW-1:0]  data_q, data_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [N-1:0]          can_acc;
    logic [N-1:0]          sel_hit;
    logic [N-1:0]          load;
    logic                  sel_oor;
    logic                  xfer;
    logic                  drop;

    // Per-channel acceptance and one-hot decode of the destination; no sel_hit bit means out of range.
    always_comb begin
        can_acc = ~valid_q | out_ready;
        sel_hit = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sel_hit[k] = (in_sel == SW'(k));
        end
        sel_oor = ~|sel_hit;
    end

    // Handshake: broadcast is all-or-nothing, out-of-range words are always sunk.
    always_comb begin
        if (in_bcast) begin
            in_ready = &can_acc;
        end else if (sel_oor) begin
            in_ready = 1'b1;
        end else begin
            in_ready = |(sel_hit & can_acc);
        end
    end

    // Next-state for channel registers and drop accounting.
    always_comb begin
        xfer   = in_valid & in_ready;
        load   = '0;
        if (xfer) begin
            load = in_bcast ? {N{1'b1}} : sel_hit;
        end
        drop   = xfer & ~in_bcast & sel_oor;
        valid_d = load | (valid_q & ~out_ready);
        data_d  = data_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (load[k]) begin
                data_d[k] = in_data;
            end
        end
        err_d = drop;
        cnt_d = cnt_q;
        if (drop && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers; reset discards every held word immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err       = err_q;
    assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: an N=8/CW=8 instance and an N=6/CW=2 instance for drop handling.
module tb_demux_stream;

    logic        clk;
    logic        rst_n;

    // Main instance (N=8)
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_bcast;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [63:0] out_data;
    logic        err;
    logic [7:0]  drop_cnt;

    // Small instance (N=6, CW=2)
    logic        in_valid6;
    logic        in_ready6;
    logic [7:0]  in_data6;
    logic [2:0]  in_sel6;
    logic        in_bcast6;
    logic [5:0]  out_valid6;
    logic [5:0]  out_ready6;
    logic [47:0] out_data6;
    logic        err6;
    logic [1:0]  drop_cnt6;

    int tests_run;
    int tests_failed;

    demux_stream #(.N(8), .DW(8), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .drop_cnt  (drop_cnt)
    );

    demux_stream #(.N(6), .DW(8), .CW(2)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .in_data   (in_data6),
        .in_sel    (in_sel6),
        .in_bcast  (in_bcast6),
        .out_valid (out_valid6),
        .out_ready (out_ready6),
        .out_data  (out_data6),
        .err       (err6),
        .drop_cnt  (drop_cnt6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0; out_ready = 8'hFF;
        in_valid6 = 0; in_data6 = 0; in_sel6 = 0; in_bcast6 = 0; out_ready6 = 6'h3F;
        #22;
        tests_run++;
        if (out_valid !== 8'h00 || out_data !== 64'h0 || err !== 1'b0 || drop_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_main: valid=%h data=%h err=%b cnt=%h, want all zero",
                     out_valid, out_data, err, drop_cnt);
        end
        tests_run++;
        if (out_valid6 !== 6'h00 || err6 !== 1'b0 || drop_cnt6 !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_small: valid=%h err=%b cnt=%0d, want all zero",
                     out_valid6, err6, drop_cnt6);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unicast();
        out_ready = 8'hFF;
        in_valid = 1; in_sel = 3; in_data = 8'hA5; in_bcast = 0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL uni_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 0;
        tests_run++;
        if (out_valid !== 8'b0000_1000 || out_data[31:24] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL uni_out: valid=%b ch3=%h, want 00001000 a5", out_valid, out_data[31:24]);
        end
        tick();
        tests_run++;
        if (out_valid !== 8'h00) begin
            tests_failed++;
            $display("FAIL uni_drain: valid=%b want 00000000", out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 8'hFB;
        in_valid = 1; in_sel = 2; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        #1;
        tests_run++;
        if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h11 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_first: v=%b d=%h rdy=%b, want 1 11 0",
                     out_valid[2], out_data[23:16], in_ready);
        end
        tick();
        tick();
        tests_run++;
        if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h11 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold: v=%b d=%h rdy=%b, want 1 11 0",
                     out_valid[2], out_data[23:16], in_ready);
        end
        out_ready = 8'hFF;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 0;
        tests_run++;
        if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h22) begin
            tests_failed++;
            $display("FAIL stall_second: v=%b d=%h, want 1 22", out_valid[2], out_data[23:16]);
        end
        tick();
        tests_run++;
        if (out_valid[2] !== 1'b0 || out_data[23:16] !== 8'h22) begin
            tests_failed++;
            $display("FAIL stall_drain: v=%b d=%h, want 0 22", out_valid[2], out_data[23:16]);
        end
    endtask

    task automatic test_independent();
        out_ready = 8'hDF;
        in_valid = 1; in_sel = 5; in_data = 8'h55;
        tick();
        in_sel = 0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hC0 + 8'(i);
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL indep_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            tests_run++;
            if (out_valid[0] !== 1'b1 || out_data[7:0] !== (8'hC0 + 8'(i)) ||
                out_valid[5] !== 1'b1 || out_data[47:40] !== 8'h55) begin
                tests_failed++;
                $display("FAIL indep_out[%0d]: v0=%b d0=%h v5=%b d5=%h, want 1 %h 1 55",
                         i, out_valid[0], out_data[7:0], out_valid[5], out_data[47:40],
                         8'hC0 + 8'(i));
            end
        end
        in_valid = 0;
    endtask

    task automatic test_broadcast();
        // ch5 drains now, ch6 gets loaded and stalls
        out_ready = 8'hBF;
        in_valid = 1; in_sel = 6; in_data = 8'h66;
        tick();
        in_bcast = 1; in_data = 8'h3C;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bcast_blocked: got %b want 0", in_ready);
        end
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || out_data[55:48] !== 8'h66 || out_valid !== 8'h40) begin
            tests_failed++;
            $display("FAIL bcast_hold: rdy=%b d6=%h valid=%h, want 0 66 40",
                     in_ready, out_data[55:48], out_valid);
        end
        out_ready = 8'hFF;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bcast_release: got %b want 1", in_ready);
        end
        tick();
        in_valid = 0; in_bcast = 0;
        tests_run++;
        if (out_valid !== 8'hFF || out_data !== {8{8'h3C}}) begin
            tests_failed++;
            $display("FAIL bcast_out: valid=%h data=%h, want ff 3c3c3c3c3c3c3c3c",
                     out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_drop();
        in_valid6 = 1; in_sel6 = 7; in_data6 = 8'h77;
        #1;
        tests_run++;
        if (in_ready6 !== 1'b1 || err6 !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_ready: rdy=%b err=%b, want 1 0", in_ready6, err6);
        end
        tick();
        in_valid6 = 0;
        tests_run++;
        if (err6 !== 1'b1 || drop_cnt6 !== 2'd1 || out_valid6 !== 6'h00) begin
            tests_failed++;
            $display("FAIL drop_first: err=%b cnt=%0d valid=%h, want 1 1 00",
                     err6, drop_cnt6, out_valid6);
        end
        tick();
        tests_run++;
        if (err6 !== 1'b0 || drop_cnt6 !== 2'd1) begin
            tests_failed++;
            $display("FAIL drop_pulse: err=%b cnt=%0d, want 0 1", err6, drop_cnt6);
        end
        in_valid6 = 1; in_sel6 = 6;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (err6 !== 1'b1 || drop_cnt6 !== ((i < 1) ? 2'd2 : 2'd3) || out_valid6 !== 6'h00) begin
                tests_failed++;
                $display("FAIL drop_b2b[%0d]: err=%b cnt=%0d valid=%h, want 1 %0d 00",
                         i, err6, drop_cnt6, out_valid6, (i < 1) ? 2 : 3);
            end
        end
        in_valid6 = 0;
        tick();
        tests_run++;
        if (err6 !== 1'b0 || drop_cnt6 !== 2'd3) begin
            tests_failed++;
            $display("FAIL drop_sat: err=%b cnt=%0d, want 0 3", err6, drop_cnt6);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 8'h00;
        in_valid = 1; in_sel = 1; in_data = 8'h01;
        tick();
        in_sel = 4; in_data = 8'h04;
        // drop on the small instance so err is high when reset hits
        in_valid6 = 1; in_sel6 = 7;
        tick();
        in_valid = 0; in_valid6 = 0;
        tests_run++;
        if (out_valid !== 8'h12 || err6 !== 1'b1 || drop_cnt6 !== 2'd3) begin
            tests_failed++;
            $display("FAIL areset_pre: valid=%h err6=%b cnt6=%0d, want 12 1 3",
                     out_valid, err6, drop_cnt6);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 8'h00 || out_data !== 64'h0 || err6 !== 1'b0 || drop_cnt6 !== 2'd0 ||
            err !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_now: valid=%h data=%h err6=%b cnt6=%0d err=%b, want 00 0 0 0 0",
                     out_valid, out_data, err6, drop_cnt6, err);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 8'hFF;
        tick();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_unicast();
        test_stall();
        test_independent();
        test_broadcast();
        test_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
